udp_rx_sample_unpack: RTL and testbench

Receive-side counterpart of the sample-to-UDP packer. Reads each received UDP payload out of the MAC receive RAM, reassembles big-endian 32-bit IQ/audio words and buffers them in a word FIFO. The block replays them one word per `sample_en` strobe toward the DAC/audio path. It sits between `mac_top`'s UDP receive interface and the sample consumer, entirely in the `gmii_rx_clk` domain.

---
 rtl/udp_rx_sample_unpack_pkg.sv | 31 +++
 rtl/udp_rx_sample_unpack_fifo.sv | 51 +++++
 rtl/udp_rx_sample_unpack.sv | 135 +++++++++++++
 tb/tb_udp_rx_sample_unpack.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/udp_rx_sample_unpack_pkg.sv
// Shared definitions for the UDP receive sample unpacker: FSM encoding,
// framing constants and small arithmetic helpers.
package udp_rx_sample_unpack_pkg;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'b0001,
    ST_CHECK = 4'b0010,
    ST_READ  = 4'b0100,
    ST_DONE  = 4'b1000
  } rx_state_t;

  localparam logic [15:0] UDP_HDR_LEN    = 16'd8;
  localparam int unsigned BYTES_PER_WORD = 4;

  // Whole payload words carried by a UDP length field, clipped to max_words.
  function automatic logic [15:0] payload_words(input logic [15:0] len,
                                                input logic [15:0] max_words);
    logic [15:0] p;
    p = (len < UDP_HDR_LEN) ? '0 : len - UDP_HDR_LEN;
    p = p >> 2;
    return (p > max_words) ? max_words : p;
  endfunction

  function automatic logic [15:0] sat_add16(input logic [15:0] cnt,
                                            input logic [1:0]  inc);
    logic [16:0] s;
    s = {1'b0, cnt} + {15'b0, inc};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

endpackage

// File: rtl/udp_rx_sample_unpack_fifo.sv
// Single-clock 32-bit word FIFO with registered read data; the storage
// array has no reset so it can map onto block RAM.
module sample_fifo #(
  parameter int unsigned DEPTH = 256
) (
  input  logic                     gmii_rx_clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [31:0]              din,
  output logic [31:0]              dout,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  // DEPTH is a power of two, so the top level bit alone marks full.
  assign do_push = push && !level[AW];
  assign do_pop  = pop && (level != '0);

  always_ff @(posedge gmii_rx_clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge gmii_rx_clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      dout   <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        dout   <= mem[rd_ptr];
      end
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/udp_rx_sample_unpack.sv
// Unpacks big-endian 32-bit sample words from received UDP payloads into a
// word FIFO and replays them one word per sample_en strobe.
module udp_rx_sample_unpack
  import udp_rx_sample_unpack_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 256,
  parameter int unsigned MAX_WORDS  = 256,
  parameter int unsigned RAM_AW     = 11
) (
  input  logic                          gmii_rx_clk,
  input  logic                          rst_n,
  input  logic                          udp_rec_data_valid,
  input  logic [15:0]                   udp_rec_data_length,
  output logic [RAM_AW-1:0]             udp_rec_ram_read_addr,
  input  logic [7:0]                    udp_rec_ram_rdata,
  input  logic                          sample_en,
  output logic [31:0]                   sample_data,
  output logic                          sample_valid,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          busy,
  output logic [15:0]                   drop_cnt,
  output logic [15:0]                   underflow_cnt
);

  rx_state_t   state;
  logic [15:0] len_q;
  logic [17:0] nbytes_q;
  logic [17:0] rd_cnt;
  logic        rd_vld;
  logic [23:0] shift_q;
  logic [1:0]  byte_cnt;

  logic [15:0] w_cnt;
  logic [16:0] free_words;
  logic        no_room;
  logic        check_drop;
  logic [1:0]  drop_inc;
  logic        fifo_empty;
  logic        fifo_push;
  logic        fifo_pop;
  logic [31:0] fifo_din;

  assign busy       = (state != ST_IDLE);
  assign w_cnt      = payload_words(len_q, 16'(MAX_WORDS));
  assign free_words = 17'(FIFO_DEPTH) - 17'(fifo_level);
  assign no_room    = ({1'b0, w_cnt} > free_words);
  assign check_drop = (state == ST_CHECK) && (w_cnt != '0) && no_room;
  assign drop_inc   = 2'(udp_rec_data_valid && busy) + 2'(check_drop);

  // The fourth byte of a word is pushed straight from the RAM bus, so the
  // word lands in the FIFO on the edge that captures that byte.
  assign fifo_push  = rd_vld && (byte_cnt == 2'd3);
  assign fifo_din   = {shift_q, udp_rec_ram_rdata};
  assign fifo_empty = (fifo_level == '0);
  assign fifo_pop   = sample_en && !fifo_empty;

  always_ff @(posedge gmii_rx_clk or negedge rst_n) begin
    if (!rst_n) begin
      state                 <= ST_IDLE;
      len_q                 <= '0;
      nbytes_q              <= '0;
      rd_cnt                <= '0;
      udp_rec_ram_read_addr <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (udp_rec_data_valid) begin
            len_q <= udp_rec_data_length;
            state <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          nbytes_q <= {w_cnt, 2'b00};
          if ((w_cnt == '0) || no_room) state <= ST_DONE;
          else                          state <= ST_READ;
        end
        ST_READ: begin
          if (rd_cnt < nbytes_q) begin
            rd_cnt <= rd_cnt + 18'd1;
            if (rd_cnt + 18'd1 < nbytes_q)
              udp_rec_ram_read_addr <= RAM_AW'(rd_cnt + 18'd1);
          end
          if (rd_vld && (rd_cnt == nbytes_q)) state <= ST_DONE;
        end
        ST_DONE: begin
          rd_cnt                <= '0;
          udp_rec_ram_read_addr <= '0;
          state                 <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge gmii_rx_clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_vld   <= 1'b0;
      shift_q  <= '0;
      byte_cnt <= '0;
    end else begin
      rd_vld <= (state == ST_READ) && (rd_cnt < nbytes_q);
      if (rd_vld) begin
        shift_q  <= {shift_q[15:0], udp_rec_ram_rdata};
        byte_cnt <= byte_cnt + 2'd1;
      end else if (state == ST_DONE) begin
        byte_cnt <= '0;
      end
    end
  end

  always_ff @(posedge gmii_rx_clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_valid  <= 1'b0;
      drop_cnt      <= '0;
      underflow_cnt <= '0;
    end else begin
      sample_valid  <= fifo_pop;
      drop_cnt      <= sat_add16(drop_cnt, drop_inc);
      underflow_cnt <= sat_add16(underflow_cnt, {1'b0, sample_en && fifo_empty});
    end
  end

  sample_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .gmii_rx_clk (gmii_rx_clk),
    .rst_n       (rst_n),
    .push        (fifo_push),
    .pop         (fifo_pop),
    .din         (fifo_din),
    .dout        (sample_data),
    .level       (fifo_level)
  );

endmodule

// File: tb/tb_udp_rx_sample_unpack.sv
// Directed bench for udp_rx_sample_unpack: table of packet lengths plus
// hand-written sequences for drop, underflow, push/pop overlap and reset.
module tb_udp_rx_sample_unpack;

  logic        gmii_rx_clk = 1'b0;
  logic        rst_n;
  logic        udp_rec_data_valid;
  logic [15:0] udp_rec_data_length;
  logic [10:0] udp_rec_ram_read_addr;
  logic [7:0]  udp_rec_ram_rdata;
  logic        sample_en;
  logic [31:0] sample_data;
  logic        sample_valid;
  logic [8:0]  fifo_level;
  logic        busy;
  logic [15:0] drop_cnt;
  logic [15:0] underflow_cnt;

  always #5 gmii_rx_clk = ~gmii_rx_clk;

  udp_rx_sample_unpack #(
    .FIFO_DEPTH (256),
    .MAX_WORDS  (256),
    .RAM_AW     (11)
  ) dut (
    .gmii_rx_clk           (gmii_rx_clk),
    .rst_n                 (rst_n),
    .udp_rec_data_valid    (udp_rec_data_valid),
    .udp_rec_data_length   (udp_rec_data_length),
    .udp_rec_ram_read_addr (udp_rec_ram_read_addr),
    .udp_rec_ram_rdata     (udp_rec_ram_rdata),
    .sample_en             (sample_en),
    .sample_data           (sample_data),
    .sample_valid          (sample_valid),
    .fifo_level            (fifo_level),
    .busy                  (busy),
    .drop_cnt              (drop_cnt),
    .underflow_cnt         (underflow_cnt)
  );

  logic [7:0] ram [2048];
  always @(posedge gmii_rx_clk) udp_rec_ram_rdata <= ram[udp_rec_ram_read_addr];

  int          total = 0;
  int          bad   = 0;
  logic [31:0] last_word;

  typedef struct {
    logic [15:0] len;
    int          words;
    int          busy_cyc;
  } vec_t;

  vec_t vecs [9];

  function automatic logic [31:0] exp_word(input int n);
    logic [7:0] b;
    b = 8'(4 * n);
    return {b, b + 8'd1, b + 8'd2, b + 8'd3};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic send_pkt(input logic [15:0] len);
    @(posedge gmii_rx_clk); #1;
    udp_rec_data_valid  = 1'b1;
    udp_rec_data_length = len;
    @(posedge gmii_rx_clk); #1;
    udp_rec_data_valid  = 1'b0;
  endtask

  task automatic wait_idle(output int cyc, output logic addr_seen);
    logic done;
    done = 1'b0;
    cyc = 0;
    addr_seen = 1'b0;
    for (int i = 0; i < 3000 && !done; i++) begin
      @(negedge gmii_rx_clk);
      if (!busy) done = 1'b1;
      else begin
        cyc++;
        if (udp_rec_ram_read_addr != '0) addr_seen = 1'b1;
      end
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL wait_idle: busy still 1 after 3000 cycles, expected 0");
    end
  endtask

  task automatic strobe();
    @(posedge gmii_rx_clk); #1;
    sample_en = 1'b1;
    @(posedge gmii_rx_clk); #1;
    sample_en = 1'b0;
  endtask

  task automatic drain(input int n, input int first);
    for (int i = 0; i < n; i++) begin
      strobe();
      check("pop_valid", 32'(sample_valid), 32'd1);
      check("pop_data", sample_data, exp_word(first + i));
      last_word = exp_word(first + i);
    end
    check("drained_level", 32'(fifo_level), 32'd0);
    @(posedge gmii_rx_clk); #1;
    check("valid_idle", 32'(sample_valid), 32'd0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int   cyc;
    logic seen;
    logic found;

    for (int i = 0; i < 2048; i++) ram[i] = 8'(i);
    vecs[0] = '{16'd408,  100, 403};
    vecs[1] = '{16'd18,   2,   11};
    vecs[2] = '{16'd7,    0,   2};
    vecs[3] = '{16'd8,    0,   2};
    vecs[4] = '{16'd11,   0,   2};
    vecs[5] = '{16'd12,   1,   7};
    vecs[6] = '{16'd15,   1,   7};
    vecs[7] = '{16'd1032, 256, 1027};
    vecs[8] = '{16'd2000, 256, 1027};

    rst_n = 1'b0;
    udp_rec_data_valid  = 1'b0;
    udp_rec_data_length = '0;
    sample_en = 1'b0;
    last_word = '0;
    repeat (3) @(posedge gmii_rx_clk);
    #1;
    check("rst_addr", 32'(udp_rec_ram_read_addr), 32'd0);
    check("rst_data", sample_data, 32'd0);
    check("rst_valid", 32'(sample_valid), 32'd0);
    check("rst_level", 32'(fifo_level), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_drop", 32'(drop_cnt), 32'd0);
    check("rst_underflow", 32'(underflow_cnt), 32'd0);
    @(negedge gmii_rx_clk);
    rst_n = 1'b1;
    repeat (2) @(posedge gmii_rx_clk);

    // Length table on an empty FIFO
    for (int v = 0; v < 9; v++) begin
      send_pkt(vecs[v].len);
      wait_idle(cyc, seen);
      check("vec_busy_cycles", 32'(cyc), 32'(vecs[v].busy_cyc));
      check("vec_level", 32'(fifo_level), 32'(vecs[v].words));
      check("vec_addr_idle", 32'(udp_rec_ram_read_addr), 32'd0);
      check("vec_drop", 32'(drop_cnt), 32'd0);
      drain(vecs[v].words, 0);
    end

    // Underflow on empty FIFO, then a single 0xDEADBEEF word
    strobe();
    check("uf_valid", 32'(sample_valid), 32'd0);
    check("uf_count", 32'(underflow_cnt), 32'd1);
    check("uf_hold_data", sample_data, last_word);
    ram[0] = 8'hDE; ram[1] = 8'hAD; ram[2] = 8'hBE; ram[3] = 8'hEF;
    send_pkt(16'd12);
    wait_idle(cyc, seen);
    for (int i = 0; i < 4; i++) ram[i] = 8'(i);
    check("dead_level", 32'(fifo_level), 32'd1);
    strobe();
    check("dead_valid", 32'(sample_valid), 32'd1);
    check("dead_data", sample_data, 32'hDEADBEEF);
    check("dead_uf_count", 32'(underflow_cnt), 32'd1);

    // Push and pop on the same edge: prefill one word, pop at end of T10
    send_pkt(16'd12);
    wait_idle(cyc, seen);
    check("pp_prefill", 32'(fifo_level), 32'd1);
    send_pkt(16'd408);
    repeat (9) @(posedge gmii_rx_clk);
    #1;
    sample_en = 1'b1;
    @(posedge gmii_rx_clk); #1;
    sample_en = 1'b0;
    check("pp_level", 32'(fifo_level), 32'd2);
    check("pp_valid", 32'(sample_valid), 32'd1);
    check("pp_data", sample_data, 32'h00010203);
    wait_idle(cyc, seen);
    check("pp_final_level", 32'(fifo_level), 32'd100);
    drain(100, 0);

    // FIFO at 200/256: a 100-word packet is dropped without any reads
    send_pkt(16'd808);
    wait_idle(cyc, seen);
    check("fill_level", 32'(fifo_level), 32'd200);
    send_pkt(16'd408);
    wait_idle(cyc, seen);
    check("drop_busy_cycles", 32'(cyc), 32'd2);
    check("drop_no_reads", 32'(seen), 32'd0);
    check("drop_cnt_full", 32'(drop_cnt), 32'd1);
    check("drop_level", 32'(fifo_level), 32'd200);
    drain(200, 0);

    // Second pulse 50 cycles into a 100-word read is dropped
    send_pkt(16'd408);
    repeat (50) @(posedge gmii_rx_clk);
    #1;
    udp_rec_data_valid  = 1'b1;
    udp_rec_data_length = 16'd18;
    @(posedge gmii_rx_clk); #1;
    udp_rec_data_valid  = 1'b0;
    check("busy_drop_cnt", 32'(drop_cnt), 32'd2);
    wait_idle(cyc, seen);
    check("busy_drop_level", 32'(fifo_level), 32'd100);
    drain(100, 0);

    // Reset mid-read with 37 words buffered
    send_pkt(16'd408);
    found = 1'b0;
    for (int i = 0; i < 1000 && !found; i++) begin
      @(negedge gmii_rx_clk);
      if (fifo_level == 9'd37) found = 1'b1;
    end
    check("mid_level_37", 32'(found), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_addr", 32'(udp_rec_ram_read_addr), 32'd0);
    check("mid_rst_data", sample_data, 32'd0);
    check("mid_rst_valid", 32'(sample_valid), 32'd0);
    check("mid_rst_level", 32'(fifo_level), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_drop", 32'(drop_cnt), 32'd0);
    check("mid_rst_underflow", 32'(underflow_cnt), 32'd0);
    repeat (2) @(posedge gmii_rx_clk);
    @(negedge gmii_rx_clk);
    rst_n = 1'b1;
    send_pkt(16'd18);
    wait_idle(cyc, seen);
    check("post_rst_busy_cycles", 32'(cyc), 32'd11);
    check("post_rst_level", 32'(fifo_level), 32'd2);
    drain(2, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
